// File: rtl/parser_pkg.sv
// rtl/parser_pkg.sv - shared constants and types for the parser ingress path
package parser_pkg;

    localparam int WIDTH     = 32;
    localparam int PKT_WORDS = 24;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin winner search starting after last_grant
module rr_picker #(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [IDX_W-1:0]   winner,
    output logic               found
);

    logic [IDX_W-1:0] idx;

    // Scan farthest offset first so the nearest requester after last_grant overwrites.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int off = NUM_SRC; off >= 1; off--) begin
            idx = IDX_W'((int'(last_grant) + off) % NUM_SRC);
            if (req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/parser_ingress_arbiter.sv
// rtl/parser_ingress_arbiter.sv - packet-granular round-robin arbiter in front of packet_parser
module parser_ingress_arbiter #(
    parameter int WIDTH     = parser_pkg::WIDTH,
    parameter int NUM_SRC   = 4,
    parameter int PKT_WORDS = parser_pkg::PKT_WORDS,
    parameter int CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SRC*WIDTH-1:0]   src_data,
    input  logic [NUM_SRC-1:0]         src_valid,
    output logic [NUM_SRC-1:0]         src_ready,
    input  logic [NUM_SRC-1:0]         src_en,
    output logic [WIDTH-1:0]           data_out,
    output logic                       valid_out,
    input  logic                       ready_out,
    output logic [$clog2(NUM_SRC)-1:0] grant_id,
    output logic                       busy,
    output logic                       pkt_done,
    output logic [NUM_SRC*CNT_W-1:0]   pkt_cnt
);

    import parser_pkg::*;

    localparam int IDX_W  = $clog2(NUM_SRC);
    localparam int BCNT_W = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
    localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(PKT_WORDS - 1);

    arb_state_t       state_q;
    arb_state_t       state_d;
    logic [IDX_W-1:0] last_grant_q;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic [BCNT_W-1:0] beat_q;
    logic [NUM_SRC-1:0] req;
    logic             sel_valid;
    logic             xfer;
    logic             last_xfer;
    logic [WIDTH-1:0] src_word [NUM_SRC];
    logic [CNT_W-1:0] cnt_q [NUM_SRC];

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        assign src_word[g]                  = src_data[g*WIDTH +: WIDTH];
        assign pkt_cnt[g*CNT_W +: CNT_W]    = cnt_q[g];
    end

    // src_en only matters here, so it is effectively sampled at arbitration time.
    assign req = src_valid & src_en;

    rr_picker #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req        (req),
        .last_grant (last_grant_q),
        .winner     (pick_idx),
        .found      (pick_found)
    );

    assign sel_valid = src_valid[grant_id];
    assign xfer      = (state_q == STREAM) && sel_valid && ready_out;
    assign last_xfer = xfer && (beat_q == LAST_BEAT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_found) state_d = STREAM;
            STREAM:  if (last_xfer)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_out  = '0;
        valid_out = 1'b0;
        src_ready = '0;
        busy      = 1'b0;
        pkt_done  = 1'b0;
        if (state_q == STREAM) begin
            data_out            = src_word[grant_id];
            valid_out           = sel_valid;
            src_ready[grant_id] = ready_out;
            busy                = 1'b1;
            pkt_done            = last_xfer;
        end
    end

    // Reset value of last_grant makes source 0 the first winner.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_id     <= '0;
            last_grant_q <= IDX_W'(NUM_SRC - 1);
            beat_q       <= '0;
        end else if (state_q == IDLE) begin
            if (pick_found) begin
                grant_id     <= pick_idx;
                last_grant_q <= pick_idx;
                beat_q       <= '0;
            end
        end else if (xfer) begin
            beat_q <= beat_q + BCNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (last_xfer && (grant_id == IDX_W'(i))) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_parser_ingress_arbiter.sv
// tb/tb_parser_ingress_arbiter.sv - self-checking bench for parser_ingress_arbiter
module tb_parser_ingress_arbiter;

    localparam int NS = 4;
    localparam int W  = 32;
    localparam int PW = 24;
    localparam int CW = 16;

    logic              clk;
    logic              rst;
    logic [NS*W-1:0]   src_data;
    logic [NS-1:0]     src_valid;
    logic [NS-1:0]     src_ready;
    logic [NS-1:0]     src_en;
    logic [W-1:0]      data_out;
    logic              valid_out;
    logic              ready_out;
    logic [1:0]        grant_id;
    logic              busy;
    logic              pkt_done;
    logic [NS*CW-1:0]  pkt_cnt;

    parser_ingress_arbiter #(
        .WIDTH     (W),
        .NUM_SRC   (NS),
        .PKT_WORDS (PW),
        .CNT_W     (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .src_data  (src_data),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_en    (src_en),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .grant_id  (grant_id),
        .busy      (busy),
        .pkt_done  (pkt_done),
        .pkt_cnt   (pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_fail;

    // Source-side stream state: each source offers base+sent until it hits its limit.
    logic [W-1:0]  base [NS];
    int            sent [NS];
    int            limit [NS];
    logic [NS-1:0] want;

    // Reference state: last winner and completed packets per source.
    int m_last;
    int m_cnt [NS];

    // Per-cycle observations captured away from the clock edge.
    logic [NS-1:0] i_valid, i_en, o_sready;
    logic          i_ready, o_valid, o_busy, o_done, o_xfer;
    logic [W-1:0]  o_data;
    logic [1:0]    o_grant;
    logic [W-1:0]  w_snap [NS];

    function automatic int rr_next(input int last, input logic [NS-1:0] elig);
        for (int off = 1; off <= NS; off++) begin
            if (elig[(last + off) % NS]) return (last + off) % NS;
        end
        return -1;
    endfunction

    function automatic logic [CW-1:0] cnt_of(input int i);
        return pkt_cnt[i*CW +: CW];
    endfunction

    task automatic refresh();
        for (int i = 0; i < NS; i++) begin
            src_data[i*W +: W] = base[i] + W'(sent[i]);
            src_valid[i]       = want[i] && (sent[i] < limit[i]);
        end
    endtask

    task automatic step();
        @(negedge clk);
        i_valid  = src_valid;
        i_en     = src_en;
        i_ready  = ready_out;
        o_valid  = valid_out;
        o_data   = data_out;
        o_grant  = grant_id;
        o_busy   = busy;
        o_done   = pkt_done;
        o_sready = src_ready;
        o_xfer   = valid_out & ready_out;
        for (int i = 0; i < NS; i++) w_snap[i] = base[i] + W'(sent[i]);
        @(posedge clk);
        for (int i = 0; i < NS; i++) if (i_valid[i] && o_sready[i]) sent[i]++;
        #1;
        refresh();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        want = '0;
        src_en = '1;
        ready_out = 1'b1;
        refresh();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_valid_out: got %b want 0", valid_out); end
        n_cmp++; if (data_out !== '0) begin n_fail++; $display("FAIL rst_data_out: got %h want 0", data_out); end
        n_cmp++; if (src_ready !== '0) begin n_fail++; $display("FAIL rst_src_ready: got %b want 0", src_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (pkt_done !== 1'b0) begin n_fail++; $display("FAIL rst_pkt_done: got %b want 0", pkt_done); end
        n_cmp++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL rst_grant_id: got %0d want 0", grant_id); end
        n_cmp++; if (pkt_cnt !== '0) begin n_fail++; $display("FAIL rst_pkt_cnt: got %h want 0", pkt_cnt); end
        rst = 1'b1;
        repeat (2) step();
        n_cmp++; if (o_busy !== 1'b0 || o_valid !== 1'b0) begin n_fail++; $display("FAIL idle_no_req: got busy=%b valid=%b want 0/0", o_busy, o_valid); end
        m_last = NS - 1;
        for (int i = 0; i < NS; i++) m_cnt[i] = 0;
    endtask

    task automatic test_reset_mid_packet();
        int beats;
        int got;
        want = '0; want[1] = 1'b1; limit[1] = sent[1] + PW;
        src_en = '1; ready_out = 1'b1;
        refresh();
        beats = 0;
        for (int c = 0; c < 60 && beats < 12; c++) begin
            step();
            if (o_xfer) beats++;
        end
        n_cmp++; if (beats !== 12) begin n_fail++; $display("FAIL midrst_reach_beat12: got %0d want 12", beats); end
        rst = 1'b0;
        #1;
        n_cmp++; if ({busy, valid_out, pkt_done} !== 3'b000) begin n_fail++; $display("FAIL midrst_flags: got busy/valid/done=%b want 000", {busy, valid_out, pkt_done}); end
        n_cmp++; if (src_ready !== '0) begin n_fail++; $display("FAIL midrst_src_ready: got %b want 0", src_ready); end
        n_cmp++; if (data_out !== '0) begin n_fail++; $display("FAIL midrst_data_out: got %h want 0", data_out); end
        n_cmp++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL midrst_grant_id: got %0d want 0", grant_id); end
        n_cmp++; if (pkt_cnt !== '0) begin n_fail++; $display("FAIL midrst_pkt_cnt: got %h want 0", pkt_cnt); end
        @(posedge clk); @(posedge clk); #1;
        want = '0; want[0] = 1'b1; want[3] = 1'b1;
        limit[0] = 32'h7fff_ffff; limit[3] = 32'h7fff_ffff;
        refresh();
        rst = 1'b1;
        got = -1;
        for (int c = 0; c < 10 && got < 0; c++) begin
            step();
            if (o_busy) got = int'(o_grant);
        end
        n_cmp++; if (got !== 0) begin n_fail++; $display("FAIL midrst_first_grant: got %0d want 0", got); end
        want = '0;
        refresh();
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        m_last = NS - 1;
        for (int i = 0; i < NS; i++) m_cnt[i] = 0;
    endtask

    task automatic test_single_source();
        int beats, dones, first_c;
        base[1] = 32'h1000_0000; sent[1] = 0; limit[1] = PW;
        want = '0; want[1] = 1'b1; src_en = '1; ready_out = 1'b1;
        refresh();
        beats = 0; dones = 0; first_c = -1;
        for (int c = 0; c < 100 && beats < PW; c++) begin
            step();
            dones += int'(o_done);
            if (o_xfer) begin
                if (first_c < 0) first_c = c;
                n_cmp++; if (o_grant !== 2'd1) begin n_fail++; $display("FAIL single_grant: got %0d want 1", o_grant); end
                n_cmp++; if (o_data !== 32'h1000_0000 + W'(beats)) begin n_fail++; $display("FAIL single_data beat %0d: got %h want %h", beats, o_data, 32'h1000_0000 + W'(beats)); end
                n_cmp++; if (o_done !== (beats == PW - 1)) begin n_fail++; $display("FAIL single_done beat %0d: got %b", beats, o_done); end
                beats++;
            end
        end
        step();
        n_cmp++; if (beats !== PW) begin n_fail++; $display("FAIL single_beats: got %0d want %0d", beats, PW); end
        n_cmp++; if (dones !== 1) begin n_fail++; $display("FAIL single_done_count: got %0d want 1", dones); end
        n_cmp++; if (first_c !== 1) begin n_fail++; $display("FAIL single_latency: got %0d want 1", first_c); end
        n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after: got %b want 0", o_busy); end
        n_cmp++; if (cnt_of(1) !== CW'(1)) begin n_fail++; $display("FAIL single_pkt_cnt1: got %0d want 1", cnt_of(1)); end
        m_last = 1; m_cnt[1]++;
    endtask

    task automatic test_round_robin();
        int seq [5];
        int s, p, pb, gap, first_c, last_c;
        s = m_last;
        for (int i = 0; i < NS; i++) limit[i] = sent[i];
        for (int k = 0; k < 5; k++) begin
            s = rr_next(s, '1);
            seq[k] = s;
            limit[s] += PW;
        end
        want = '1; src_en = '1; ready_out = 1'b1;
        refresh();
        p = 0; pb = 0; gap = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 200 && p < 5; c++) begin
            step();
            if (o_xfer) begin
                if (first_c < 0) first_c = c;
                if (pb == 0) begin
                    n_cmp++; if (o_grant !== 2'(seq[p])) begin n_fail++; $display("FAIL rr_grant pkt %0d: got %0d want %0d", p, o_grant, seq[p]); end
                    if (p > 0) begin
                        n_cmp++; if (gap !== 1) begin n_fail++; $display("FAIL rr_bubble pkt %0d: got %0d want 1", p, gap); end
                    end
                end
                n_cmp++; if (o_data !== w_snap[seq[p]]) begin n_fail++; $display("FAIL rr_data pkt %0d beat %0d: got %h want %h", p, pb, o_data, w_snap[seq[p]]); end
                pb++;
                if (o_done) begin
                    n_cmp++; if (pb !== PW) begin n_fail++; $display("FAIL rr_pkt_len pkt %0d: got %0d want %0d", p, pb, PW); end
                    m_cnt[seq[p]]++; m_last = seq[p];
                    last_c = c; p++; pb = 0; gap = 0;
                end
            end else begin
                gap++;
            end
        end
        step();
        n_cmp++; if (p !== 5) begin n_fail++; $display("FAIL rr_packets: got %0d want 5", p); end
        n_cmp++; if (last_c - first_c + 1 !== 5 * (PW + 1) - 1) begin n_fail++; $display("FAIL rr_throughput: got %0d cycles want %0d", last_c - first_c + 1, 5 * (PW + 1) - 1); end
        for (int i = 0; i < NS; i++) begin
            n_cmp++; if (cnt_of(i) !== CW'(m_cnt[i])) begin n_fail++; $display("FAIL rr_pkt_cnt%0d: got %0d want %0d", i, cnt_of(i), m_cnt[i]); end
        end
    endtask

    task automatic test_ready_stall();
        int beats, dones, s0, exp_g;
        logic stalled;
        exp_g = rr_next(m_last, 4'b0001);
        s0 = sent[0]; limit[0] = sent[0] + PW;
        want = '0; want[0] = 1'b1; src_en = '1; ready_out = 1'b1;
        refresh();
        beats = 0; dones = 0; stalled = 1'b0;
        for (int c = 0; c < 100 && beats < PW; c++) begin
            step();
            dones += int'(o_done);
            if (o_xfer) begin
                n_cmp++; if (o_grant !== 2'(exp_g) || o_data !== base[0] + W'(s0 + beats)) begin n_fail++; $display("FAIL stall_xfer beat %0d: got g=%0d d=%h want g=%0d d=%h", beats, o_grant, o_data, exp_g, base[0] + W'(s0 + beats)); end
                n_cmp++; if (o_done !== (beats == PW - 1)) begin n_fail++; $display("FAIL stall_done beat %0d: got %b", beats, o_done); end
                beats++;
            end
            if (beats == 10 && !stalled) begin
                stalled = 1'b1;
                ready_out = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    step();
                    n_cmp++; if (o_data !== base[0] + W'(s0 + 10)) begin n_fail++; $display("FAIL stall_hold_data: got %h want %h", o_data, base[0] + W'(s0 + 10)); end
                    n_cmp++; if (o_sready !== '0 || o_valid !== 1'b1 || o_busy !== 1'b1) begin n_fail++; $display("FAIL stall_hold_ctrl: got ready=%b valid=%b busy=%b want 0000/1/1", o_sready, o_valid, o_busy); end
                end
                ready_out = 1'b1;
            end
        end
        step();
        n_cmp++; if (beats !== PW || dones !== 1) begin n_fail++; $display("FAIL stall_total: got beats=%0d dones=%0d want %0d/1", beats, dones, PW); end
        m_last = exp_g; m_cnt[exp_g]++;
    endtask

    task automatic test_valid_drop();
        int grants [2];
        int p, pb;
        logic dropped;
        int exp0;
        exp0 = rr_next(m_last, 4'b1100);
        limit[2] = sent[2] + PW; limit[3] = sent[3] + PW;
        want = 4'b1100; src_en = '1; ready_out = 1'b1;
        refresh();
        p = 0; pb = 0; dropped = 1'b0; grants[0] = -1; grants[1] = -1;
        for (int c = 0; c < 200 && p < 2; c++) begin
            step();
            if (o_xfer) begin
                if (pb == 0) grants[p] = int'(o_grant);
                n_cmp++; if (o_data !== w_snap[o_grant]) begin n_fail++; $display("FAIL drop_data pkt %0d beat %0d: got %h want %h", p, pb, o_data, w_snap[o_grant]); end
                pb++;
                if (o_done) begin p++; pb = 0; end
            end
            if (p == 0 && pb == 7 && !dropped) begin
                dropped = 1'b1;
                want[2] = 1'b0; refresh();
                for (int k = 0; k < 5; k++) begin
                    step();
                    n_cmp++; if (o_busy !== 1'b1 || o_grant !== 2'd2 || o_valid !== 1'b0 || o_sready !== 4'b0100) begin n_fail++; $display("FAIL drop_hold: got busy=%b g=%0d valid=%b ready=%b want 1/2/0/0100", o_busy, o_grant, o_valid, o_sready); end
                end
                want[2] = 1'b1; refresh();
            end
        end
        step();
        n_cmp++; if (grants[0] !== exp0 || grants[0] !== 2) begin n_fail++; $display("FAIL drop_first_grant: got %0d want 2", grants[0]); end
        n_cmp++; if (grants[1] !== 3) begin n_fail++; $display("FAIL drop_second_grant: got %0d want 3", grants[1]); end
        want = '0; refresh();
        m_last = 3; m_cnt[2]++; m_cnt[3]++;
    endtask

    task automatic test_en_clear();
        int grants [2];
        int p, pb, busy_cycles;
        logic cleared;
        limit[2] = 32'h7fff_ffff;
        want = 4'b0100; src_en = '1; ready_out = 1'b1;
        refresh();
        p = 0; pb = 0; cleared = 1'b0; grants[0] = -1; grants[1] = -1;
        for (int c = 0; c < 200 && p < 2; c++) begin
            step();
            if (o_xfer) begin
                if (pb == 0) grants[p] = int'(o_grant);
                pb++;
                if (o_done) begin p++; pb = 0; end
            end
            if (p == 0 && pb == 5 && !cleared) begin
                cleared = 1'b1;
                src_en[2] = 1'b0;
                want[1] = 1'b1; limit[1] = sent[1] + PW;
                refresh();
            end
        end
        busy_cycles = 0;
        for (int c = 0; c < 60; c++) begin
            step();
            busy_cycles += int'(o_busy);
        end
        n_cmp++; if (grants[0] !== 2) begin n_fail++; $display("FAIL en_first_grant: got %0d want 2", grants[0]); end
        n_cmp++; if (grants[1] !== 1) begin n_fail++; $display("FAIL en_second_grant: got %0d want 1", grants[1]); end
        n_cmp++; if (busy_cycles !== 0) begin n_fail++; $display("FAIL en_masked_regrant: got %0d busy cycles want 0", busy_cycles); end
        want = '0; src_en = '1; refresh();
        m_last = 1; m_cnt[2]++; m_cnt[1]++;
    endtask

    task automatic test_random();
        logic          m_busy;
        int            m_grant, m_beats, g;
        logic [NS-1:0] elig, exp_rdy;
        logic          x;
        m_busy = 1'b0; m_grant = 0; m_beats = 0;
        for (int i = 0; i < NS; i++) limit[i] = 32'h7fff_ffff;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NS; i++) begin
                want[i]   = ($urandom_range(0, 3) != 0);
                src_en[i] = ($urandom_range(0, 7) != 0);
            end
            ready_out = ($urandom_range(0, 3) != 0);
            refresh();
            step();
            if (!m_busy) begin
                n_cmp++; if ({o_busy, o_valid, o_done} !== 3'b000 || o_sready !== '0) begin n_fail++; $display("FAIL rand_idle cyc %0d: got busy/valid/done=%b ready=%b want 000/0000", c, {o_busy, o_valid, o_done}, o_sready); end
                elig = i_valid & i_en;
                if (elig != '0) begin
                    m_grant = rr_next(m_last, elig);
                    m_last = m_grant; m_busy = 1'b1; m_beats = 0;
                end
            end else begin
                g = m_grant;
                exp_rdy = i_ready ? (NS'(1) << g) : '0;
                x = i_valid[g] && i_ready;
                n_cmp++; if (o_busy !== 1'b1 || o_grant !== 2'(g) || o_valid !== i_valid[g] || o_sready !== exp_rdy) begin n_fail++; $display("FAIL rand_stream cyc %0d: got busy=%b g=%0d valid=%b ready=%b want 1/%0d/%b/%b", c, o_busy, o_grant, o_valid, o_sready, g, i_valid[g], exp_rdy); end
                n_cmp++; if (o_done !== (x && m_beats == PW - 1)) begin n_fail++; $display("FAIL rand_done cyc %0d: got %b want %b", c, o_done, x && m_beats == PW - 1); end
                if (i_valid[g]) begin
                    n_cmp++; if (o_data !== w_snap[g]) begin n_fail++; $display("FAIL rand_data cyc %0d: got %h want %h", c, o_data, w_snap[g]); end
                end
                if (x) begin
                    m_beats++;
                    if (m_beats == PW) begin
                        m_cnt[g]++; m_busy = 1'b0;
                    end
                end
            end
        end
        for (int i = 0; i < NS; i++) begin
            n_cmp++; if (cnt_of(i) !== CW'(m_cnt[i])) begin n_fail++; $display("FAIL rand_pkt_cnt%0d: got %0d want %0d", i, cnt_of(i), m_cnt[i]); end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        for (int i = 0; i < NS; i++) begin
            base[i]  = W'(i) << 28;
            sent[i]  = 0;
            limit[i] = 0;
        end
        want = '0;
        src_data = '0;
        src_valid = '0;
        src_en = '1;
        ready_out = 1'b1;
        test_reset();
        test_reset_mid_packet();
        test_single_source();
        test_round_robin();
        test_ready_stall();
        test_valid_drop();
        test_en_clear();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
